// File: rtl/decode_stage.sv
// Decode stage of the RV32I-subset pipeline: register file with write-back bypass,
// instruction decode, immediate generation and load-use / control hazard detection.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrD,
  input  logic [31:0] pcD,
  input  logic [31:0] pcPlus4D,
  input  logic        regWriteW,
  input  logic [4:0]  rdW,
  input  logic [31:0] resultW,
  input  logic [1:0]  resultSrcE,
  input  logic [4:0]  rdE,
  input  logic        pcSrcE,
  output logic [31:0] pcOutD,
  output logic [31:0] pcPlus4OutD,
  output logic [31:0] rd1D,
  output logic [31:0] rd2D,
  output logic [4:0]  rs1AddrD,
  output logic [4:0]  rs2AddrD,
  output logic [4:0]  rdAddrD,
  output logic [31:0] immExtD,
  output logic        regWriteD,
  output logic        memWriteD,
  output logic        jumpD,
  output logic        branchD,
  output logic        aluSrcD,
  output logic [1:0]  resultSrcD,
  output logic [2:0]  aluControlD,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        flushE
);

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [31:0] r_regs [32];
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_bypass1;
  logic        w_bypass2;
  logic        w_lw_stall;
  imm_src_t    w_imm_src;
  logic [2:0]  w_alu_op;
  logic        w_alu_legal;

  assign w_opcode    = instrD[6:0];
  assign w_funct3    = instrD[14:12];
  assign rs1AddrD    = instrD[19:15];
  assign rs2AddrD    = instrD[24:20];
  assign rdAddrD     = instrD[11:7];
  assign pcOutD      = pcD;
  assign pcPlus4OutD = pcPlus4D;

  // Asynchronous clear of the whole file; x0 is never written so it stays 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) r_regs[k] <= '0;
    end else if (regWriteW && rdW != 5'd0) begin
      r_regs[rdW] <= resultW;
    end
  end

  assign w_bypass1 = regWriteW && (rdW != 5'd0) && (rdW == rs1AddrD);
  assign w_bypass2 = regWriteW && (rdW != 5'd0) && (rdW == rs2AddrD);

  assign rd1D = (reset || rs1AddrD == 5'd0) ? 32'd0 : (w_bypass1 ? resultW : r_regs[rs1AddrD]);
  assign rd2D = (reset || rs2AddrD == 5'd0) ? 32'd0 : (w_bypass2 ? resultW : r_regs[rs2AddrD]);

  // funct3 -> ALU op for R-type and I-ALU; instrD[30] selects sub only for R-type.
  always_comb begin
    w_alu_op    = 3'b000;
    w_alu_legal = 1'b1;
    case (w_funct3)
      3'b000:  w_alu_op = (w_opcode == OP_R && instrD[30]) ? 3'b001 : 3'b000;
      3'b010:  w_alu_op = 3'b101;
      3'b110:  w_alu_op = 3'b011;
      3'b111:  w_alu_op = 3'b010;
      default: w_alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    regWriteD   = 1'b0;
    memWriteD   = 1'b0;
    jumpD       = 1'b0;
    branchD     = 1'b0;
    aluSrcD     = 1'b0;
    resultSrcD  = 2'b00;
    aluControlD = 3'b000;
    w_imm_src   = IMM_NONE;
    case (w_opcode)
      OP_LW: begin
        regWriteD  = 1'b1;
        aluSrcD    = 1'b1;
        resultSrcD = 2'b01;
        w_imm_src  = IMM_I;
      end
      OP_SW: begin
        memWriteD = 1'b1;
        aluSrcD   = 1'b1;
        w_imm_src = IMM_S;
      end
      OP_R: begin
        if (w_alu_legal) begin
          regWriteD   = 1'b1;
          aluControlD = w_alu_op;
        end
      end
      OP_IALU: begin
        if (w_alu_legal) begin
          regWriteD   = 1'b1;
          aluSrcD     = 1'b1;
          aluControlD = w_alu_op;
          w_imm_src   = IMM_I;
        end
      end
      OP_BEQ: begin
        branchD     = 1'b1;
        aluControlD = 3'b001;
        w_imm_src   = IMM_B;
      end
      OP_JAL: begin
        regWriteD  = 1'b1;
        jumpD      = 1'b1;
        resultSrcD = 2'b10;
        w_imm_src  = IMM_J;
      end
      default: ;
    endcase
  end

  always_comb begin
    immExtD = 32'd0;
    case (w_imm_src)
      IMM_I:   immExtD = {{20{instrD[31]}}, instrD[31:20]};
      IMM_S:   immExtD = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
      IMM_B:   immExtD = {{20{instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
      IMM_J:   immExtD = {{12{instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
      default: immExtD = 32'd0;
    endcase
  end

  // Raw rs2 field is compared even for formats that do not read rs2 (conservative).
  assign w_lw_stall = (resultSrcE == 2'b01) && (rdE != 5'd0) &&
                      ((rdE == rs1AddrD) || (rdE == rs2AddrD));

  assign stallF = w_lw_stall;
  assign stallD = w_lw_stall;
  assign flushD = pcSrcE;
  assign flushE = w_lw_stall | pcSrcE;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: register file, bypass, decode,
// immediates, hazards and asynchronous reset.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instrD, pcD, pcPlus4D, resultW;
  logic        regWriteW, pcSrcE;
  logic [4:0]  rdW, rdE;
  logic [1:0]  resultSrcE;
  logic [31:0] pcOutD, pcPlus4OutD, rd1D, rd2D, immExtD;
  logic [4:0]  rs1AddrD, rs2AddrD, rdAddrD;
  logic        regWriteD, memWriteD, jumpD, branchD, aluSrcD;
  logic [1:0]  resultSrcD;
  logic [2:0]  aluControlD;
  logic        stallF, stallD, flushD, flushE;

  int n_checks = 0;
  int n_errors = 0;

  decode_stage dut (
    .clk(clk), .reset(reset), .instrD(instrD), .pcD(pcD), .pcPlus4D(pcPlus4D),
    .regWriteW(regWriteW), .rdW(rdW), .resultW(resultW),
    .resultSrcE(resultSrcE), .rdE(rdE), .pcSrcE(pcSrcE),
    .pcOutD(pcOutD), .pcPlus4OutD(pcPlus4OutD), .rd1D(rd1D), .rd2D(rd2D),
    .rs1AddrD(rs1AddrD), .rs2AddrD(rs2AddrD), .rdAddrD(rdAddrD), .immExtD(immExtD),
    .regWriteD(regWriteD), .memWriteD(memWriteD), .jumpD(jumpD), .branchD(branchD),
    .aluSrcD(aluSrcD), .resultSrcD(resultSrcD), .aluControlD(aluControlD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  function automatic logic [31:0] ctrl();
    return {22'd0, regWriteD, memWriteD, jumpD, branchD, aluSrcD, resultSrcD, aluControlD};
  endfunction

  function automatic logic [31:0] haz();
    return {28'd0, stallF, stallD, flushD, flushE};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [9:0]  ctl;  // regWrite,memWrite,jump,branch,aluSrc,resultSrc[1:0],aluControl[2:0]
  } dec_vec_t;

  dec_vec_t dec_tbl[12] = '{
    '{"addi_m4",  32'hFFC00093, 32'hFFFFFFFC, 10'b1_0_0_0_1_00_000},
    '{"beq_m8",   32'hFE000CE3, 32'hFFFFFFF8, 10'b0_0_0_1_0_00_001},
    '{"jal_2048", 32'h0010006F, 32'h00000800, 10'b1_0_1_0_0_10_000},
    '{"lw_4",     32'h0041A083, 32'h00000004, 10'b1_0_0_0_1_01_000},
    '{"sw_8",     32'h0021A423, 32'h00000008, 10'b0_1_0_0_1_00_000},
    '{"sub",      32'h403100B3, 32'h00000000, 10'b1_0_0_0_0_00_001},
    '{"slt",      32'h003120B3, 32'h00000000, 10'b1_0_0_0_0_00_101},
    '{"or",       32'h003160B3, 32'h00000000, 10'b1_0_0_0_0_00_011},
    '{"and",      32'h003170B3, 32'h00000000, 10'b1_0_0_0_0_00_010},
    '{"slti_m1",  32'hFFF12093, 32'hFFFFFFFF, 10'b1_0_0_0_1_00_101},
    '{"addi_b30", 32'h40010093, 32'h00000400, 10'b1_0_0_0_1_00_000},
    '{"illegal",  32'h0000007F, 32'h00000000, 10'b0_0_0_0_0_00_000}
  };

  initial begin
    reset = 1'b1; instrD = 32'h000280B3; pcD = 32'h0000_0100; pcPlus4D = 32'h0000_0104;
    regWriteW = 1'b1; rdW = 5'd5; resultW = 32'h5555_5555;
    resultSrcE = 2'b00; rdE = 5'd0; pcSrcE = 1'b0;

    // Reset held across an edge: bypass and write both suppressed.
    @(posedge clk); #1;
    check("reset_bypass_rd1", rd1D, 32'd0);
    @(negedge clk);
    reset = 1'b0; regWriteW = 1'b0;
    #1 check("reset_x5_rd1", rd1D, 32'd0);

    check("pc_pass", pcOutD, 32'h0000_0100);
    check("pc4_pass", pcPlus4OutD, 32'h0000_0104);

    // Write x5, then read via add x1,x5,x0.
    regWriteW = 1'b1; rdW = 5'd5; resultW = 32'hDEADBEEF; instrD = 32'h0000007F;
    @(negedge clk);
    regWriteW = 1'b0; instrD = 32'h000280B3;
    #1;
    check("add_rd1_x5", rd1D, 32'hDEADBEEF);
    check("add_rd2_x0", rd2D, 32'd0);
    check("add_ctrl", ctrl(), 32'b1_0_0_0_0_00_000);

    // Same-cycle bypass on rs2 = x7.
    @(negedge clk);
    regWriteW = 1'b1; rdW = 5'd7; resultW = 32'h0000_1234; instrD = 32'h00700133;
    #1 check("bypass_rd2_x7", rd2D, 32'h0000_1234);
    @(negedge clk);
    regWriteW = 1'b0;
    #1 check("stored_rd2_x7", rd2D, 32'h0000_1234);

    // x0 write ignored.
    @(negedge clk);
    regWriteW = 1'b1; rdW = 5'd0; resultW = 32'h0000_FFFF; instrD = 32'h000000B3;
    #1 check("x0_bypass", rd1D, 32'd0);
    @(negedge clk);
    regWriteW = 1'b0;
    #1 check("x0_read", rd1D, 32'd0);

    // Decode / immediate table.
    foreach (dec_tbl[i]) begin
      @(negedge clk);
      instrD = dec_tbl[i].instr;
      #1;
      check({dec_tbl[i].name, "_imm"}, immExtD, dec_tbl[i].imm);
      check({dec_tbl[i].name, "_ctrl"}, ctrl(), {22'd0, dec_tbl[i].ctl});
    end

    // Illegal R-type funct3 (sll) is a bubble.
    @(negedge clk);
    instrD = 32'h003110B3;
    #1;
    check("sll_ctrl", ctrl(), 32'd0);
    check("sll_imm", immExtD, 32'd0);

    // Register address fields of sub x1,x2,x3.
    instrD = 32'h403100B3;
    #1 check("sub_addrs", {17'd0, rs1AddrD, rs2AddrD, rdAddrD}, {17'd0, 5'd2, 5'd3, 5'd1});

    // Hazards: lw x1,4(x3) has rs1=3 and raw rs2 field = 4.
    instrD = 32'h0041A083;
    resultSrcE = 2'b01; rdE = 5'd3; pcSrcE = 1'b0;
    #1 check("lw_use_rs1", haz(), 32'b1101);
    rdE = 5'd4;
    #1 check("lw_use_rs2_raw", haz(), 32'b1101);
    rdE = 5'd0;
    #1 check("lw_use_rd0", haz(), 32'b0000);
    resultSrcE = 2'b00; rdE = 5'd3;
    #1 check("alu_in_ex", haz(), 32'b0000);
    pcSrcE = 1'b1;
    #1 check("ctrl_flush", haz(), 32'b0011);
    resultSrcE = 2'b01;
    #1 check("lw_and_flush", haz(), 32'b1111);
    resultSrcE = 2'b00; pcSrcE = 1'b0; rdE = 5'd0;

    // Asynchronous reset pulse between edges clears x5.
    @(negedge clk);
    instrD = 32'h000280B3;
    #1 check("x5_before_reset", rd1D, 32'hDEADBEEF);
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check("x5_after_async_reset", rd1D, 32'd0);

    // Write pending across reset deassertion: first edge after release writes.
    @(negedge clk);
    reset = 1'b1; regWriteW = 1'b1; rdW = 5'd5; resultW = 32'h0000_A5A5;
    #1 check("reset_bypass_suppressed", rd1D, 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    regWriteW = 1'b0;
    #1 check("write_after_release", rd1D, 32'h0000_A5A5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
